// File: rtl/gate_exer_pkg.sv
// -----------------------------------------------------------------------------
// gate_exer_pkg
// Shared types and helpers for the gate exerciser:
//   gate_op_e     - selectable 2-input gate function
//   exer_state_e  - exerciser sequencing states
//   gate_eval     - golden model of the selected gate function
//   lfsr_feedback - Fibonacci LFSR feedback bit (parity of tapped bits)
//   LFSR_SEED / LFSR_TAPS - LFSR reload value and tap mask (x^8+x^6+x^5+x^4+1)
// -----------------------------------------------------------------------------
package gate_exer_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'd0,
        OP_OR   = 2'd1,
        OP_XOR  = 2'd2,
        OP_NAND = 2'd3
    } gate_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } exer_state_e;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Expected gate output for the latched function.
    function automatic logic gate_eval(input gate_op_e op, input logic a, input logic b);
        logic x;
        case (op)
            OP_AND:  x = a & b;
            OP_OR:   x = a | b;
            OP_XOR:  x = a ^ b;
            OP_NAND: x = ~(a & b);
            default: x = 1'b0;
        endcase
        return x;
    endfunction

    // Feedback bit of the Fibonacci LFSR: parity of the tapped register bits.
    function automatic logic lfsr_feedback(input logic [7:0] q);
        return ^(q & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/gate_exer_lfsr.sv
// -----------------------------------------------------------------------------
// gate_exer_lfsr
// 8-bit Fibonacci LFSR that sources pseudo-random gate vectors. Only built
// when GATE_EXER_LFSR_EN is defined.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset (reloads the seed)
//   load  - reload LFSR_SEED (has priority over step)
//   step  - advance one position
//   q     - current register value
// -----------------------------------------------------------------------------
`ifdef GATE_EXER_LFSR_EN
module gate_exer_lfsr
    import gate_exer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       step,
    output logic [7:0] q
);

    // Shift register: seed on reset/load, shift in the tap parity on step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= LFSR_SEED;
        end else if (load) begin
            q <= LFSR_SEED;
        end else if (step) begin
            q <= {q[6:0], lfsr_feedback(q)};
        end else begin
            q <= q;
        end
    end

endmodule
`endif

// File: rtl/gate_exerciser.sv
// -----------------------------------------------------------------------------
// gate_exerciser
// Drives a 2-input gate under test through a vector sequence, waits a settle
// time per vector, samples the gate output against a golden model and
// accumulates pass/fail counts, truth-table coverage and the first failure.
//
// Optional feature macro: GATE_EXER_LFSR_EN
//   defined   - adds rand_i; rand_i=1 at start sources vectors from an 8-bit
//               LFSR (seed reloaded each start), rand_i=0 stays exhaustive.
//   undefined - vectors are always exhaustive {a,b} = 00,01,10,11,...
//
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   start_i           - start pulse, accepted in IDLE or DONE only
//   op_i              - gate function latched at start (AND/OR/XOR/NAND)
//   rand_i            - (GATE_EXER_LFSR_EN only) LFSR vector select
//   a_o, b_o          - gate-under-test inputs
//   x_i               - gate-under-test output
//   busy_o            - high while settling/sampling
//   done_o            - high once the run finished, until next start/reset
//   pass_cnt_o        - matching samples (saturating)
//   fail_cnt_o        - mismatching samples (saturating)
//   ff_vld_o          - first-failure record valid
//   ff_vec_o          - first failing {a,b,x}
//   ff_idx_o          - vector index of first failure
//   cov_o             - truth-table rows sampled, bit index {a,b}
// -----------------------------------------------------------------------------
module gate_exerciser
    import gate_exer_pkg::*;
#(
    parameter  int NUM_VECTORS   = 16,
    parameter  int SETTLE_CYCLES = 1,
    parameter  int CNT_W         = 16,
    localparam int IDX_W         = $clog2(NUM_VECTORS) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [1:0]       op_i,
`ifdef GATE_EXER_LFSR_EN
    input  logic             rand_i,
`endif
    output logic             a_o,
    output logic             b_o,
    input  logic             x_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    output logic             ff_vld_o,
    output logic [2:0]       ff_vec_o,
    output logic [IDX_W-1:0] ff_idx_o,
    output logic [3:0]       cov_o
);

    // Settle counter is at least one bit wide even when no settling is used.
    localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0]  SC_LAST  = SC_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
    localparam logic [SC_W-1:0]  SC_ONE   = SC_W'(32'd1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VECTORS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    // State entered whenever a new vector is applied.
    localparam exer_state_e ST_APPLY  = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;

    exer_state_e      state_r;
    gate_op_e         op_r;
    logic [IDX_W-1:0] idx_r;
    logic [SC_W-1:0]  settle_cnt_r;

    logic             start_acc_s;
    logic             exp_x_s;
    logic             mismatch_s;
    logic             last_vec_s;
    logic [1:0]       first_vec_s;
    logic [1:0]       next_vec_s;

`ifdef GATE_EXER_LFSR_EN
    logic             rand_r;
    logic [7:0]       lfsr_q_s;
    logic             lfsr_step_s;

    // The LFSR advances once per sampled vector.
    always_comb begin
        if (state_r == ST_SAMPLE) begin
            lfsr_step_s = 1'b1;
        end else begin
            lfsr_step_s = 1'b0;
        end
    end

    gate_exer_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (start_acc_s),
        .step  (lfsr_step_s),
        .q     (lfsr_q_s)
    );
`endif

    // Start qualification, golden compare and next-vector selection.
    always_comb begin
        start_acc_s = 1'b0;
        if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
            start_acc_s = start_i;
        end else begin
            start_acc_s = 1'b0;
        end

        exp_x_s    = gate_eval(op_r, a_o, b_o);
        // 4-state compare so an X/Z from the gate is scored as a mismatch.
        mismatch_s = (x_i !== exp_x_s);
        last_vec_s = (idx_r == IDX_LAST);

`ifdef GATE_EXER_LFSR_EN
        if (rand_i) begin
            first_vec_s = LFSR_SEED[1:0];
        end else begin
            first_vec_s = 2'b00;
        end
        // Low two bits of the LFSR after its next step: {q[0], feedback}.
        if (rand_r) begin
            next_vec_s = {lfsr_q_s[0], lfsr_feedback(lfsr_q_s)};
        end else begin
            next_vec_s = {a_o, b_o} + 2'd1;
        end
`else
        first_vec_s = 2'b00;
        // Exhaustive mode: {a,b} always equals idx[1:0], so just count up.
        next_vec_s  = {a_o, b_o} + 2'd1;
`endif
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            op_r         <= OP_AND;
            idx_r        <= '0;
            settle_cnt_r <= '0;
            a_o          <= 1'b0;
            b_o          <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            pass_cnt_o   <= '0;
            fail_cnt_o   <= '0;
            ff_vld_o     <= 1'b0;
            ff_vec_o     <= 3'b000;
            ff_idx_o     <= '0;
            cov_o        <= 4'b0000;
`ifdef GATE_EXER_LFSR_EN
            rand_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_acc_s) begin
                        op_r         <= gate_op_e'(op_i);
`ifdef GATE_EXER_LFSR_EN
                        rand_r       <= rand_i;
`endif
                        idx_r        <= '0;
                        settle_cnt_r <= '0;
                        {a_o, b_o}   <= first_vec_s;
                        pass_cnt_o   <= '0;
                        fail_cnt_o   <= '0;
                        ff_vld_o     <= 1'b0;
                        ff_vec_o     <= 3'b000;
                        ff_idx_o     <= '0;
                        cov_o        <= 4'b0000;
                        busy_o       <= 1'b1;
                        done_o       <= 1'b0;
                        state_r      <= ST_APPLY;
                    end else begin
                        state_r      <= state_r;
                    end
                end

                ST_SETTLE: begin
                    if (settle_cnt_r == SC_LAST) begin
                        settle_cnt_r <= '0;
                        state_r      <= ST_SAMPLE;
                    end else begin
                        settle_cnt_r <= settle_cnt_r + SC_ONE;
                    end
                end

                ST_SAMPLE: begin
                    if (mismatch_s) begin
                        if (fail_cnt_o != CNT_MAX) begin
                            fail_cnt_o <= fail_cnt_o + CNT_ONE;
                        end else begin
                            fail_cnt_o <= fail_cnt_o;
                        end
                        // Only the first failure of a run is recorded.
                        if (!ff_vld_o) begin
                            ff_vld_o <= 1'b1;
                            ff_vec_o <= {a_o, b_o, x_i};
                            ff_idx_o <= idx_r;
                        end else begin
                            ff_vld_o <= ff_vld_o;
                        end
                    end else begin
                        if (pass_cnt_o != CNT_MAX) begin
                            pass_cnt_o <= pass_cnt_o + CNT_ONE;
                        end else begin
                            pass_cnt_o <= pass_cnt_o;
                        end
                    end

                    cov_o[{a_o, b_o}] <= 1'b1;

                    if (last_vec_s) begin
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        idx_r        <= idx_r + IDX_ONE;
                        {a_o, b_o}   <= next_vec_s;
                        settle_cnt_r <= '0;
                        state_r      <= ST_APPLY;
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_exerciser.sv
// -----------------------------------------------------------------------------
// tb_gate_exerciser
// Three exerciser instances with different parameters, each driving a
// behavioural gate whose fault mode the stimulus selects. Stimulus pushes the
// expected run result into a queue; a monitor pops and compares on every
// rising done_o.
//   inst 0: defaults (16 vectors, settle 1, 16-bit counters)
//   inst 1: 3 vectors, settle 0
//   inst 2: 8 vectors, settle 0, 2-bit counters (saturation)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gate_exerciser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [1:0] op_i;
    logic [2:0] start_s;
    logic [2:0] x_s;
    logic [2:0] a_s, b_s, busy_s, done_s, vld_s;
`ifdef GATE_EXER_LFSR_EN
    logic       rand_i;
`endif

    logic [15:0] pc [3];
    logic [15:0] fc [3];
    logic [4:0]  fi [3];
    logic [2:0]  fv [3];
    logic [3:0]  cv [3];

    logic [15:0] pc0, fc0, pc1, fc1;
    logic [1:0]  pc2, fc2;
    logic [4:0]  fi0;
    logic [2:0]  fi1;
    logic [3:0]  fi2;

    assign pc[0] = pc0;
    assign fc[0] = fc0;
    assign fi[0] = fi0;
    assign pc[1] = pc1;
    assign fc[1] = fc1;
    assign fi[1] = {2'b00, fi1};
    assign pc[2] = {14'd0, pc2};
    assign fc[2] = {14'd0, fc2};
    assign fi[2] = {1'b0, fi2};

    // Behavioural gate-under-test: 0 correct, 1 stuck-at-1, 2 stuck-at-0.
    int         mode [3];
    logic [1:0] gsel [3];

    function automatic logic golden(input logic [1:0] op, input logic a, input logic b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    always_comb begin
        x_s = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (mode[i] == 1)      x_s[i] = 1'b1;
            else if (mode[i] == 2) x_s[i] = 1'b0;
            else                   x_s[i] = golden(gsel[i], a_s[i], b_s[i]);
        end
    end

    gate_exerciser u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start_s[0]), .op_i(op_i),
`ifdef GATE_EXER_LFSR_EN
        .rand_i(rand_i),
`endif
        .a_o(a_s[0]), .b_o(b_s[0]), .x_i(x_s[0]), .busy_o(busy_s[0]), .done_o(done_s[0]),
        .pass_cnt_o(pc0), .fail_cnt_o(fc0), .ff_vld_o(vld_s[0]), .ff_vec_o(fv[0]),
        .ff_idx_o(fi0), .cov_o(cv[0])
    );

    gate_exerciser #(.NUM_VECTORS(3), .SETTLE_CYCLES(0), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start_s[1]), .op_i(op_i),
`ifdef GATE_EXER_LFSR_EN
        .rand_i(rand_i),
`endif
        .a_o(a_s[1]), .b_o(b_s[1]), .x_i(x_s[1]), .busy_o(busy_s[1]), .done_o(done_s[1]),
        .pass_cnt_o(pc1), .fail_cnt_o(fc1), .ff_vld_o(vld_s[1]), .ff_vec_o(fv[1]),
        .ff_idx_o(fi1), .cov_o(cv[1])
    );

    gate_exerciser #(.NUM_VECTORS(8), .SETTLE_CYCLES(0), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start_s[2]), .op_i(op_i),
`ifdef GATE_EXER_LFSR_EN
        .rand_i(rand_i),
`endif
        .a_o(a_s[2]), .b_o(b_s[2]), .x_i(x_s[2]), .busy_o(busy_s[2]), .done_o(done_s[2]),
        .pass_cnt_o(pc2), .fail_cnt_o(fc2), .ff_vld_o(vld_s[2]), .ff_vec_o(fv[2]),
        .ff_idx_o(fi2), .cov_o(cv[2])
    );

    typedef struct {
        int          inst;
        int          start_cyc;
        int          lat;
        logic [15:0] pass;
        logic [15:0] fail;
        logic        vld;
        logic [2:0]  vec;
        logic [4:0]  idx;
        logic [3:0]  cov;
        logic [63:0] sig;
    } exp_t;

    exp_t sbq [$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference a/b trace: each vector is seen for (1+settle) cycles.
    function automatic logic [63:0] ref_sig(input int n, input int s, input bit rnd);
        logic [7:0]  q;
        logic [1:0]  v;
        logic [63:0] r;
        q = 8'hA5;
        r = 64'd0;
        for (int k = 0; k < n; k++) begin
            v = rnd ? q[1:0] : 2'(k);
            for (int j = 0; j <= s; j++) r = {r[61:0], v};
            q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
        return r;
    endfunction

    // Monitor: trace a/b while busy, score each run on the rising edge of done.
    initial begin
        int          busy_cnt [3];
        logic [63:0] sig      [3];
        logic [2:0]  done_q;
        exp_t        e;
        done_q = 3'b000;
        for (int i = 0; i < 3; i++) begin
            busy_cnt[i] = 0;
            sig[i]      = 64'd0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    busy_cnt[i] = 0;
                    sig[i]      = 64'd0;
                end else begin
                    if (busy_s[i]) begin
                        busy_cnt[i]++;
                        sig[i] = {sig[i][61:0], a_s[i], b_s[i]};
                    end
                    if (done_s[i] && !done_q[i]) begin
                        if (sbq.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_done inst=%0d got done=1 expected no run", i);
                        end else begin
                            e = sbq.pop_front();
                            chk("inst",    64'(i),           64'(e.inst));
                            chk("latency", 64'(cyc - e.start_cyc - 1), 64'(e.lat));
                            chk("busy_cycles", 64'(busy_cnt[i]), 64'(e.lat));
                            chk("pass_cnt", 64'(pc[i]),      64'(e.pass));
                            chk("fail_cnt", 64'(fc[i]),      64'(e.fail));
                            chk("ff_vld",   64'(vld_s[i]),   64'(e.vld));
                            chk("ff_vec",   64'(fv[i]),      64'(e.vec));
                            chk("ff_idx",   64'(fi[i]),      64'(e.idx));
                            chk("cov",      64'(cv[i]),      64'(e.cov));
                            chk("vec_trace", sig[i],         e.sig);
                        end
                        busy_cnt[i] = 0;
                        sig[i]      = 64'd0;
                    end
                end
                done_q[i] = done_s[i];
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (sbq.size() != 0 && t < 400) begin
            @(posedge clk);
            t++;
        end
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL run_timeout: got %0d pending runs expected 0", sbq.size());
            sbq.delete();
        end
        @(negedge clk);
    endtask

    // Launch one run; optionally re-pulse start (with a different op) mid-run.
    task automatic launch(input int inst, input logic [1:0] op, input int md, input int n,
                          input int s, input bit rnd, input int pass, input int fail,
                          input logic [2:0] vec, input int idx, input logic [3:0] cov,
                          input int pulse_at);
        exp_t e;
        mode[inst] = md;
        gsel[inst] = op;
        @(negedge clk);
        op_i = op;
`ifdef GATE_EXER_LFSR_EN
        rand_i = rnd;
`endif
        start_s[inst] = 1'b1;
        @(posedge clk);
        #1;
        start_s[inst] = 1'b0;
        op_i = ~op;
        e.inst = inst;  e.start_cyc = cyc;  e.lat = n * (1 + s);
        e.pass = 16'(pass);  e.fail = 16'(fail);  e.vld = (fail != 0);
        e.vec = vec;  e.idx = 5'(idx);  e.cov = cov;  e.sig = ref_sig(n, s, rnd);
        sbq.push_back(e);
        if (pulse_at > 0) begin
            repeat (pulse_at - 1) @(posedge clk);
            @(negedge clk);
            start_s[inst] = 1'b1;
            op_i = op ^ 2'd2;
            @(negedge clk);
            start_s[inst] = 1'b0;
        end
    endtask

    task automatic run(input int inst, input logic [1:0] op, input int md, input int n,
                       input int s, input bit rnd, input int pass, input int fail,
                       input logic [2:0] vec, input int idx, input logic [3:0] cov,
                       input int pulse_at);
        launch(inst, op, md, n, s, rnd, pass, fail, vec, idx, cov, pulse_at);
        wait_idle();
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_ab"},   64'({a_s[0], b_s[0]}), 64'd0);
        chk({tag, "_busy"}, 64'(busy_s),  64'd0);
        chk({tag, "_done"}, 64'(done_s),  64'd0);
        chk({tag, "_pass"}, 64'(pc[0]),   64'd0);
        chk({tag, "_fail"}, 64'(fc[0]),   64'd0);
        chk({tag, "_vld"},  64'(vld_s),   64'd0);
        chk({tag, "_vec"},  64'(fv[0]),   64'd0);
        chk({tag, "_idx"},  64'(fi[0]),   64'd0);
        chk({tag, "_cov"},  64'(cv[0]),   64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            mode[i] = 0;
            gsel[i] = 2'd0;
        end
        rst_n   = 1'b0;
        op_i    = 2'd3;
        start_s = 3'b111;
`ifdef GATE_EXER_LFSR_EN
        rand_i  = 1'b1;
`endif
        // Reset held two cycles with start asserted: nothing may be accepted.
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        @(negedge clk);
        start_s = 3'b000;
        rst_n   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_reset_busy", 64'(busy_s), 64'd0);
        chk("post_reset_done", 64'(done_s), 64'd0);

        // inst op   mode n  s rnd pass fail vec     idx cov    pulse
        run(0, 2'd0, 0, 16, 1, 1'b0, 16,  0, 3'b000, 0, 4'hF, 0);  // AND, good gate
        run(0, 2'd0, 1, 16, 1, 1'b0,  4, 12, 3'b001, 0, 4'hF, 0);  // AND, stuck-at-1
        run(0, 2'd1, 0, 16, 1, 1'b0, 16,  0, 3'b000, 0, 4'hF, 0);  // OR, good gate
        run(0, 2'd3, 1, 16, 1, 1'b0, 12,  4, 3'b111, 3, 4'hF, 0);  // NAND, stuck-at-1
        run(1, 2'd2, 0,  3, 0, 1'b0,  3,  0, 3'b000, 0, 4'h7, 0);  // XOR, no settle
        run(1, 2'd2, 2,  3, 0, 1'b0,  1,  2, 3'b010, 1, 4'h7, 0);  // XOR, stuck-at-0
        run(2, 2'd0, 0,  8, 0, 1'b0,  3,  0, 3'b000, 0, 4'hF, 0);  // pass saturates
        run(2, 2'd0, 1,  8, 0, 1'b0,  2,  3, 3'b001, 0, 4'hF, 0);  // fail saturates
        run(0, 2'd0, 0, 16, 1, 1'b0, 16,  0, 3'b000, 0, 4'hF, 5);  // start ignored mid-run

        // Reset at cycle 10 of a run aborts it; a restart runs clean.
        launch(0, 2'd0, 1, 16, 1, 1'b0, 4, 12, 3'b001, 0, 4'hF, 0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("abort");
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 2'd0, 0, 16, 1, 1'b0, 16,  0, 3'b000, 0, 4'hF, 0);

`ifdef GATE_EXER_LFSR_EN
        // Two back-to-back LFSR runs must replay the same sequence.
        run(0, 2'd1, 0, 16, 1, 1'b1, 16,  0, 3'b000, 0, 4'hF, 0);
        run(0, 2'd1, 0, 16, 1, 1'b1, 16,  0, 3'b000, 0, 4'hF, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
